// File: rtl/mbtrain_resp.sv
// Mainband-training responder: answers the partner's sideband MBTRAIN requests for the five
// substeps and checks the alternating 5555/AAAA mainband pattern in each substep's window.

package SB_codex_pkg;

    // Per-substep codes sit at 1 + 4*index: START_REQ, START_RESP, END_REQ, END_RESP.
    typedef enum logic [4:0] {
        SB_NONE                           = 5'd0,
        MBTRAIN_VALVREF_START_REQ         = 5'd1,
        MBTRAIN_VALVREF_START_RESP        = 5'd2,
        MBTRAIN_VALVREF_END_REQ           = 5'd3,
        MBTRAIN_VALVREF_END_RESP          = 5'd4,
        MBTRAIN_DATAVREF_START_REQ        = 5'd5,
        MBTRAIN_DATAVREF_START_RESP       = 5'd6,
        MBTRAIN_DATAVREF_END_REQ          = 5'd7,
        MBTRAIN_DATAVREF_END_RESP         = 5'd8,
        MBTRAIN_VALTRAINCENTER_START_REQ  = 5'd9,
        MBTRAIN_VALTRAINCENTER_START_RESP = 5'd10,
        MBTRAIN_VALTRAINCENTER_END_REQ    = 5'd11,
        MBTRAIN_VALTRAINCENTER_END_RESP   = 5'd12,
        MBTRAIN_DATATRAINCENTER_START_REQ = 5'd13,
        MBTRAIN_DATATRAINCENTER_START_RESP = 5'd14,
        MBTRAIN_DATATRAINCENTER_END_REQ   = 5'd15,
        MBTRAIN_DATATRAINCENTER_END_RESP  = 5'd16,
        MBTRAIN_LINKSPEED_START_REQ       = 5'd17,
        MBTRAIN_LINKSPEED_START_RESP      = 5'd18,
        MBTRAIN_LINKSPEED_END_REQ         = 5'd19,
        MBTRAIN_LINKSPEED_END_RESP        = 5'd20,
        MBTRAIN_RESULT_REQ                = 5'd21,
        MBTRAIN_RESULT_RESP               = 5'd22
    } SB_msg_t;

endpackage

module mbtrain_resp
    import SB_codex_pkg::*;
#(
    parameter int unsigned CHECK_CYCLES = 64,
    parameter int unsigned ERR_THRESH   = 0,
    parameter int unsigned TIMEOUT_CYC  = 1000
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [15:0] MB_dataPins_RX_i,
    input  SB_msg_t     RX_msg_i,
    input  logic        RX_msg_valid_i,
    output logic        RX_msg_req_o,
    output SB_msg_t     TX_msg_o,
    output logic [15:0] TX_data_o,
    output logic        TX_msg_valid_o,
    input  logic        TX_msg_ready_i,
    output logic        MTRAIN_done_o,
    output logic        MTRAIN_err_o
);

    localparam int unsigned ErrW  = $clog2(CHECK_CYCLES + 1);
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ErrW-1:0]  ChkLast  = ErrW'(CHECK_CYCLES - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        StIdle,
        StWaitStart,
        StSendStart,
        StCheck,
        StWaitRes,
        StSendRes,
        StWaitEnd,
        StSendEnd,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        sub_q, sub_d;
    logic [ErrW-1:0]   chk_cnt_q, chk_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [ErrW-1:0]   err_cnt_q [16];
    logic [ErrW-1:0]   err_cnt_d [16];

    logic              in_wait;
    logic              pop;
    logic              tx_valid;
    logic              tx_fire;
    logic [15:0]       exp_word;
    logic [15:0]       mismatch;
    logic [15:0]       pass_mask;
    SB_msg_t           start_req, start_resp, end_req, end_resp;

    assign start_req  = SB_msg_t'({sub_q, 2'b00} + 5'd1);
    assign start_resp = SB_msg_t'({sub_q, 2'b00} + 5'd2);
    assign end_req    = SB_msg_t'({sub_q, 2'b00} + 5'd3);
    assign end_resp   = SB_msg_t'({sub_q, 2'b00} + 5'd4);

    assign in_wait  = (state_q == StWaitStart) || (state_q == StWaitRes) ||
                      (state_q == StWaitEnd);
    assign tx_valid = (state_q == StSendStart) || (state_q == StSendRes) ||
                      (state_q == StSendEnd);
    assign tx_fire  = tx_valid && TX_msg_ready_i;

    // Even check cycles expect 5555, odd ones AAAA.
    assign exp_word = chk_cnt_q[0] ? 16'hAAAA : 16'h5555;
    assign mismatch = MB_dataPins_RX_i ^ exp_word;

    always_comb begin
        pass_mask = '0;
        for (int i = 0; i < 16; i++) begin
            pass_mask[i] = (32'(err_cnt_q[i]) <= ERR_THRESH);
        end
    end

    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        chk_cnt_d  = chk_cnt_q;
        wait_cnt_d = '0;
        err_cnt_d  = err_cnt_q;
        pop        = 1'b0;

        if (!enable_i) begin
            state_d   = StIdle;
            sub_d     = '0;
            chk_cnt_d = '0;
            for (int i = 0; i < 16; i++) begin
                err_cnt_d[i] = '0;
            end
        end else begin
            // Shared wait handling: pop whenever a message is offered, otherwise run the timeout.
            if (in_wait) begin
                if (RX_msg_valid_i) begin
                    pop = 1'b1;
                end else if (wait_cnt_q >= WaitLast) begin
                    state_d = StError;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    state_d = StWaitStart;
                    sub_d   = '0;
                end
                StWaitStart: begin
                    if (pop) state_d = (RX_msg_i == start_req) ? StSendStart : StError;
                end
                StSendStart: begin
                    if (tx_fire) begin
                        state_d   = StCheck;
                        chk_cnt_d = '0;
                        for (int i = 0; i < 16; i++) begin
                            err_cnt_d[i] = '0;
                        end
                    end
                end
                StCheck: begin
                    for (int i = 0; i < 16; i++) begin
                        if (mismatch[i] && (err_cnt_q[i] != '1)) begin
                            err_cnt_d[i] = err_cnt_q[i] + 1'b1;
                        end
                    end
                    if (chk_cnt_q == ChkLast) begin
                        state_d = StWaitRes;
                    end else begin
                        chk_cnt_d = chk_cnt_q + 1'b1;
                    end
                end
                StWaitRes: begin
                    if (pop) state_d = (RX_msg_i == MBTRAIN_RESULT_REQ) ? StSendRes : StError;
                end
                StSendRes: begin
                    if (tx_fire) state_d = StWaitEnd;
                end
                StWaitEnd: begin
                    if (pop) state_d = (RX_msg_i == end_req) ? StSendEnd : StError;
                end
                StSendEnd: begin
                    if (tx_fire) begin
                        if (sub_q == 3'd4) begin
                            state_d = StDone;
                        end else begin
                            state_d = StWaitStart;
                            sub_d   = sub_q + 3'd1;
                        end
                    end
                end
                StDone:  state_d = StDone;
                StError: state_d = StError;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        RX_msg_req_o   = pop;
        TX_msg_valid_o = tx_valid;
        TX_msg_o       = SB_NONE;
        TX_data_o      = '0;
        MTRAIN_done_o  = (state_q == StDone);
        MTRAIN_err_o   = (state_q == StError);
        unique case (state_q)
            StSendStart: TX_msg_o = start_resp;
            StSendRes: begin
                TX_msg_o  = MBTRAIN_RESULT_RESP;
                TX_data_o = pass_mask;
            end
            StSendEnd:   TX_msg_o = end_resp;
            default:     TX_msg_o = SB_NONE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            sub_q      <= '0;
            chk_cnt_q  <= '0;
            wait_cnt_q <= '0;
            for (int i = 0; i < 16; i++) begin
                err_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            chk_cnt_q  <= chk_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            for (int i = 0; i < 16; i++) begin
                err_cnt_q[i] <= err_cnt_d[i];
            end
        end
    end

endmodule
